// File: rtl/game_sequencer.sv
// game_sequencer: round sequencer for a basketball game (countdown, timed play, shot animation, scoring).
// Define GAME_SEQUENCER_BONUS_EN to score made shots ending with time_left<=10 as 3 points instead of 2.
module game_sequencer #(
    parameter int GAME_SECONDS      = 60,
    parameter int COUNTDOWN_SECONDS = 3,
    parameter int FRAMES_PER_SHOT   = 50
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       sec_tick,
    input  logic       frame_tick,
    input  logic       start,
    input  logic       shot_req,
    input  logic       make,
    output logic       shot_ack,
    output logic       div_clear,
    output logic [2:0] state,
    output logic [1:0] cd_left,
    output logic [6:0] time_left,
    output logic [7:0] score,
    output logic [5:0] anim_frame,
    output logic       game_over
);
    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_COUNTDOWN = 3'd1;
    localparam logic [2:0] S_PLAY      = 3'd2;
    localparam logic [2:0] S_SHOT      = 3'd3;
    localparam logic [2:0] S_OVER      = 3'd4;

    logic [2:0] r_state;
    logic [1:0] r_cd;
    logic [6:0] r_tl;
    logic [7:0] r_score;
    logic [5:0] r_anim;
    logic       r_ack;
    logic       r_dc;

    logic [6:0] w_tl_dec;
    logic       w_last;
    logic [8:0] w_pts;
    logic [8:0] w_sum;

    // Time left after this cycle's tick; shot outcome and state decisions use this value.
    assign w_tl_dec = (sec_tick && r_tl != 7'd0) ? r_tl - 7'd1 : r_tl;
    assign w_last   = r_anim == 6'(FRAMES_PER_SHOT - 1);
`ifdef GAME_SEQUENCER_BONUS_EN
    assign w_pts    = (w_tl_dec <= 7'd10) ? 9'd3 : 9'd2;
`else
    assign w_pts    = 9'd2;
`endif
    assign w_sum    = {1'b0, r_score} + w_pts;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= S_IDLE;
            r_cd    <= 2'd0;
            r_tl    <= 7'd0;
            r_score <= 8'd0;
            r_anim  <= 6'd0;
            r_ack   <= 1'b0;
            r_dc    <= 1'b0;
        end else begin
            r_ack <= 1'b0;
            r_dc  <= 1'b0;
            case (r_state)
                S_IDLE, S_OVER: begin
                    if (start) begin
                        r_state <= S_COUNTDOWN;
                        r_cd    <= 2'(COUNTDOWN_SECONDS);
                        r_tl    <= 7'(GAME_SECONDS);
                        r_score <= 8'd0;
                        r_dc    <= 1'b1;
                    end
                end
                S_COUNTDOWN: begin
                    if (sec_tick) begin
                        r_cd    <= r_cd - 2'd1;
                        r_state <= (r_cd == 2'd1) ? S_PLAY : S_COUNTDOWN;
                    end
                end
                S_PLAY: begin
                    r_tl <= w_tl_dec;
                    if (w_tl_dec == 7'd0) begin
                        r_state <= S_OVER;
                    end else if (shot_req) begin
                        r_state <= S_SHOT;
                        r_ack   <= 1'b1;
                        r_anim  <= 6'd0;
                    end
                end
                S_SHOT: begin
                    r_tl <= w_tl_dec;
                    if (frame_tick) begin
                        r_anim <= w_last ? 6'd0 : r_anim + 6'd1;
                        if (w_last) begin
                            if (make)
                                r_score <= w_sum[8] ? 8'hFF : w_sum[7:0];
                            r_state <= (w_tl_dec != 7'd0) ? S_PLAY : S_OVER;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign state      = r_state;
    assign cd_left    = r_cd;
    assign time_left  = r_tl;
    assign score      = r_score;
    assign anim_frame = r_anim;
    assign shot_ack   = r_ack;
    assign div_clear  = r_dc;
    assign game_over  = r_state == S_OVER;
endmodule

// File: tb/tb_game_sequencer.sv
// tb_game_sequencer: scoreboard bench for game_sequencer against a behavioural round model.
module tb_game_sequencer;
    localparam int GS = 5;
    localparam int CD = 3;
    localparam int FR = 4;

    logic       clk = 1'b0;
    logic       resetn = 1'b1;
    logic       sec_tick = 1'b0, frame_tick = 1'b0, start = 1'b0, shot_req = 1'b0, make = 1'b0;
    logic       shot_ack, div_clear, game_over;
    logic [2:0] state;
    logic [1:0] cd_left;
    logic [6:0] time_left;
    logic [7:0] score;
    logic [5:0] anim_frame;

    game_sequencer #(.GAME_SECONDS(GS), .COUNTDOWN_SECONDS(CD), .FRAMES_PER_SHOT(FR)) dut (
        .clk(clk), .resetn(resetn), .sec_tick(sec_tick), .frame_tick(frame_tick),
        .start(start), .shot_req(shot_req), .make(make), .shot_ack(shot_ack),
        .div_clear(div_clear), .state(state), .cd_left(cd_left), .time_left(time_left),
        .score(score), .anim_frame(anim_frame), .game_over(game_over)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0] st;
        logic [1:0] cd;
        logic [6:0] tl;
        logic [7:0] sc;
        logic [5:0] an;
        logic       ack;
        logic       dc;
        logic       go;
    } obs_t;

    obs_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    typedef enum int {IDLE = 0, COUNTDOWN = 1, PLAY = 2, SHOT = 3, OVER = 4} phase_t;
    phase_t m_ph = IDLE;
    int m_cd = 0, m_tl = 0, m_sc = 0, m_frame = 0;
    bit m_ack = 0, m_dc = 0;

    function automatic obs_t dut_obs();
        return '{state, cd_left, time_left, score, anim_frame, shot_ack, div_clear, game_over};
    endfunction

    function automatic obs_t model_obs();
        return '{3'(int'(m_ph)), 2'(m_cd), 7'(m_tl), 8'(m_sc), 6'(m_frame), m_ack, m_dc, m_ph == OVER};
    endfunction

    task automatic compare(input string name, input obs_t a, input obs_t e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s got st=%0d cd=%0d tl=%0d sc=%0d an=%0d ack=%0b dc=%0b go=%0b want st=%0d cd=%0d tl=%0d sc=%0d an=%0d ack=%0b dc=%0b go=%0b",
                name, a.st, a.cd, a.tl, a.sc, a.an, a.ack, a.dc, a.go,
                e.st, e.cd, e.tl, e.sc, e.an, e.ack, e.dc, e.go);
        end
    endtask

    // One clock of the round rules: a second ticks the clock down, a frame advances the animation.
    task automatic model_step(input bit sec, input bit frm, input bit st, input bit req, input bit mk);
        int pts;
        m_ack = 0;
        m_dc  = 0;
        if (m_ph == IDLE || m_ph == OVER) begin
            if (st) begin
                m_ph = COUNTDOWN; m_cd = CD; m_tl = GS; m_sc = 0; m_dc = 1;
            end
        end else if (m_ph == COUNTDOWN) begin
            if (sec) begin
                m_cd = m_cd - 1;
                if (m_cd == 0) m_ph = PLAY;
            end
        end else begin
            if (sec && m_tl > 0) m_tl = m_tl - 1;
            if (m_ph == PLAY) begin
                if (m_tl == 0) m_ph = OVER;
                else if (req) begin m_ph = SHOT; m_ack = 1; m_frame = 0; end
            end else if (frm) begin
                m_frame = m_frame + 1;
                if (m_frame == FR) begin
`ifdef GAME_SEQUENCER_BONUS_EN
                    pts = (m_tl <= 10) ? 3 : 2;
`else
                    pts = 2;
`endif
                    if (mk) m_sc = (m_sc + pts > 255) ? 255 : m_sc + pts;
                    m_frame = 0;
                    m_ph = (m_tl > 0) ? PLAY : OVER;
                end
            end
        end
    endtask

    task automatic cyc(input bit sec, input bit frm, input bit st, input bit req, input bit mk);
        @(negedge clk);
        sec_tick = sec; frame_tick = frm; start = st; shot_req = req; make = mk;
        model_step(sec, frm, st, req, mk);
        exp_q.push_back(model_obs());
    endtask

    task automatic do_reset();
        @(negedge clk);
        sec_tick = 0; frame_tick = 0; start = 0; shot_req = 0; make = 0;
        #1 resetn = 1'b0;
        #1;
        m_ph = IDLE; m_cd = 0; m_tl = 0; m_sc = 0; m_frame = 0; m_ack = 0; m_dc = 0;
        compare("async_reset", dut_obs(), model_obs());
        @(negedge clk);
        resetn = 1'b1;
    endtask

    task automatic to_play();
        cyc(0, 0, 1, 0, 0);
        repeat (CD) begin cyc(0, 0, 0, 0, 0); cyc(1, 0, 0, 0, 0); end
    endtask

    task automatic shot(input bit mk);
        cyc(0, 0, 0, 1, 0);
        repeat (FR) cyc(0, 1, 0, 0, mk);
    endtask

    initial begin : monitor
        obs_t e;
        forever begin
            @(posedge clk);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                compare("cycle", dut_obs(), e);
            end
        end
    end

    initial begin : driver
        bit req_hold;
        do_reset();
        cyc(0, 0, 0, 1, 0);
        cyc(0, 0, 1, 0, 0);
        cyc(0, 0, 0, 1, 0);
        repeat (CD) cyc(1, 0, 0, 1, 0);
        cyc(0, 0, 1, 0, 0);
        shot(1);
        repeat (GS - 1) cyc(1, 0, 0, 0, 0);
        cyc(0, 0, 0, 1, 0);
        cyc(0, 1, 0, 0, 1);
        cyc(1, 0, 0, 0, 1);
        repeat (FR - 1) cyc(0, 1, 0, 0, 1);
        repeat (2) cyc(0, 0, 0, 0, 0);
        to_play();
        repeat (GS - 1) cyc(1, 0, 0, 0, 0);
        cyc(1, 0, 0, 1, 0);
        cyc(0, 0, 0, 1, 0);
        to_play();
        cyc(0, 0, 0, 1, 0);
        cyc(0, 1, 0, 0, 1);
        do_reset();
        to_play();
        repeat (130) shot(1);
        shot(0);
        req_hold = 0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 599) == 0) begin
                do_reset();
                req_hold = 0;
            end
            req_hold = req_hold ? !m_ack : ($urandom_range(0, 2) == 0);
            cyc($urandom_range(0, 5) == 0, $urandom_range(0, 1) == 1,
                $urandom_range(0, 19) == 0, req_hold, $urandom_range(0, 1) == 1);
        end
        cyc(0, 0, 0, 0, 0);
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
        if (exp_q.size() > 0) begin
            errors++;
            $display("FAIL drain pending=%0d want 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/game_sequencer.md
GAME_SEQUENCER -- requirements
Module: game_sequencer

Interface
REQ-001 SHALL have parameter GAME_SECONDS, default 60: length of one round in seconds, 1..127.
REQ-002 SHALL have parameter COUNTDOWN_SECONDS, default 3: pre-round countdown length, 1..3.
REQ-003 SHALL have parameter FRAMES_PER_SHOT, default 50: animation frames per shot, 2..63.
REQ-004 clk  in  1  single clock; all logic on its rising edge.
REQ-005 resetn  in  1  reset, asynchronous, active-low.
REQ-006 sec_tick  in  1  one-cycle pulse per second from the clock divider.
REQ-007 frame_tick  in  1  one-cycle pulse per animation frame from the clock divider.
REQ-008 start  in  1  player start button, sampled each cycle.
REQ-009 shot_req  in  1  shot request, held until shot_ack.
REQ-010 make  in  1  basket result, sampled on the last frame of a shot.
REQ-011 shot_ack  out  1  one-cycle acceptance pulse for shot_req.
REQ-012 div_clear  out  1  one-cycle pulse realigning the clock divider.
REQ-013 state  out  3  IDLE=0, COUNTDOWN=1, PLAY=2, SHOT=3, OVER=4.
REQ-014 cd_left  out  2  countdown seconds remaining.
REQ-015 time_left  out  7  round seconds remaining.
REQ-016 score  out  8  round score.
REQ-017 anim_frame  out  6  current shot animation frame.
REQ-018 game_over  out  1  high while state==OVER.

Function
REQ-019 IDLE or OVER with start=1 SHALL go to COUNTDOWN next cycle, loading cd_left=COUNTDOWN_SECONDS, time_left=GAME_SECONDS and score=0, and pulsing div_clear for that one cycle.
REQ-020 COUNTDOWN SHALL decrement cd_left on each sec_tick; a sec_tick with cd_left==1 SHALL move to PLAY with cd_left=0.
REQ-021 PLAY and SHOT SHALL decrement time_left on each sec_tick; time_left SHALL saturate at 0.
REQ-022 PLAY with shot_req=1 and time_left>0 after this cycle's tick SHALL pulse shot_ack one cycle, enter SHOT and set anim_frame=0.
REQ-023 In PLAY, a sec_tick taking time_left to 0 SHALL move to OVER; a same-cycle shot_req SHALL get no ack.
REQ-024 SHOT SHALL increment anim_frame on each frame_tick; a frame_tick at anim_frame==FRAMES_PER_SHOT-1 ends the shot.
REQ-025 At shot end, make=1 SHALL add 2 to score, saturating at 255; next state SHALL be PLAY if time_left>0, else OVER.
REQ-026 A shot in flight when time_left reaches 0 SHALL complete and score (buzzer-beater), then go to OVER.
REQ-027 shot_req outside PLAY SHALL be ignored (no ack); start outside IDLE/OVER SHALL be ignored.
REQ-028 sec_tick and frame_tick in the same cycle SHALL both take effect.
REQ-029 OVER SHALL hold score and time_left=0 until start.
REQ-030 anim_frame SHALL read 0 outside SHOT.

Reset
REQ-031 resetn=0 SHALL asynchronously force state=IDLE, cd_left=0, time_left=0, score=0, anim_frame=0, shot_ack=0, div_clear=0, game_over=0.
REQ-032 Reset mid-round or mid-shot SHALL abandon the round with no score update; start is first honoured on the first clock after resetn returns to 1.

Configuration
REQ-033 With GAME_SEQUENCER_BONUS_EN defined, a made shot whose end falls while time_left<=10 SHALL add 3 instead of 2, also saturating at 255.
REQ-034 Without GAME_SEQUENCER_BONUS_EN, every made shot SHALL add 2.

Verification (GAME_SECONDS=5, COUNTDOWN_SECONDS=3, FRAMES_PER_SHOT=4)
REQ-035 Reset, then start pulse -> div_clear=1 one cycle, state=1, cd_left=3; after 3 sec_ticks -> state=2, time_left=5.
REQ-036 In PLAY, shot_req held -> shot_ack one cycle, state=3; 4 frame_ticks with make=1 -> score=2, state=2, anim_frame=0.
REQ-037 Shot started at time_left=1, sec_tick mid-shot -> time_left=0, shot completes, make=1 -> score=2 (3 with BONUS_EN), state=4, game_over=1.
REQ-038 PLAY at time_left=1, sec_tick and shot_req in the same cycle -> no shot_ack, state=4.
REQ-039 shot_req in IDLE/COUNTDOWN -> no shot_ack; start during PLAY -> no change; resetn=0 mid-SHOT -> all outputs 0, state=0 immediately, without waiting for a clock edge.
REQ-040 Score preloaded near full, made shot -> score saturates at 255.
